// File: rtl/gdp_pkg.sv
// Shared constants and state encoding for the GDP senone store.
// Sizes, stat-word field offsets and the storage-side FSM states live here.
package gdp_pkg;

  localparam int N_COMPONENTS = 25;
  localparam int N_SENONES    = 256;
  localparam int TOTAL        = N_SENONES * N_COMPONENTS;
  localparam int PTR_W        = $clog2(TOTAL);
  localparam int SADDR_W      = $clog2(N_SENONES);

  localparam int STAT_W  = 48;
  localparam int SCORE_W = 16;

  localparam int MEAN_LSB  = 0;
  localparam int OMEGA_LSB = 16;
  localparam int K_LSB     = 32;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2,
    ST_SERVE   = 2'd3
  } state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port synchronous RAM, one write and one read port, read-first.
// Only the read-data register is reset; it holds its value when not reading.
module sdp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Reading the array with <= in a separate process returns pre-write data (read-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/senone_store.sv
// Storage-side responder for the GDP controller: preloaded stat stream,
// senone score capture and a host score read port.
module senone_store
  import gdp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               new_vector,
  input  logic               get_data,
  output logic [STAT_W-1:0]  stat_data,
  output logic               stat_valid,
  input  logic               write_data,
  input  logic [SADDR_W-1:0] data_addr,
  input  logic [SCORE_W-1:0] data_out,
  input  logic               gdp_done,
  input  logic               load_start,
  input  logic               load_en,
  input  logic [STAT_W-1:0]  load_data,
  output logic               load_done,
  input  logic               rd_en,
  input  logic [SADDR_W-1:0] rd_addr,
  output logic [SCORE_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               scores_ready,
  output logic               busy,
  output logic               stat_overrun
);

  state_t             r_state, w_next_state;
  logic [PTR_W-1:0]   r_rd_ptr, r_ld_ptr;
  logic               r_stat_valid, r_load_done, r_rd_valid;
  logic               r_scores_ready, r_busy, r_overrun;

  logic               w_load_restart, w_nv_acc, w_serve, w_ld_we;
  logic               w_last_rd, w_last_ld;
  logic [PTR_W-1:0]   w_stat_raddr;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_EMPTY;
    else        r_state <= w_next_state;
  end

  // Decoded controls; an accepted new_vector rewinds the read address to 0 in the same cycle.
  always_comb begin
    // NOTE: every signal gets a value before any branch so no latch is inferred.
    w_load_restart = 1'b0;
    w_nv_acc       = 1'b0;
    w_serve        = 1'b0;
    w_ld_we        = 1'b0;
    w_load_restart = load_start && (r_state != ST_SERVE);
    w_nv_acc       = new_vector &&
                     ((r_state == ST_SERVE) || ((r_state == ST_READY) && !load_start));
    w_serve        = get_data && ((r_state == ST_SERVE) || w_nv_acc);
    w_ld_we        = (r_state == ST_LOADING) && load_en && !load_start;
    w_stat_raddr   = w_nv_acc ? '0 : r_rd_ptr;
    w_last_rd      = w_serve && (w_stat_raddr == LAST_IDX);
    w_last_ld      = w_ld_we && (r_ld_ptr == LAST_IDX);
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_EMPTY:   if (load_start) w_next_state = ST_LOADING;
      ST_LOADING: if (load_start)     w_next_state = ST_LOADING;
                  else if (w_last_ld) w_next_state = ST_READY;
      ST_READY,
      ST_SERVE: begin
        if (w_load_restart) w_next_state = ST_LOADING;
        else if (w_last_rd) w_next_state = ST_READY;
        else if (w_nv_acc)  w_next_state = ST_SERVE;
      end
      default:    w_next_state = ST_EMPTY;
    endcase
  end

  // Pointers and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr       <= '0;
      r_ld_ptr       <= '0;
      r_stat_valid   <= 1'b0;
      r_load_done    <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_scores_ready <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      // NOTE: state uses <= so every register samples the pre-edge values of its peers.
      if (w_serve)       r_rd_ptr <= w_last_rd ? '0 : w_stat_raddr + PTR_W'(1);
      else if (w_nv_acc) r_rd_ptr <= '0;

      if (w_load_restart) r_ld_ptr <= '0;
      else if (w_ld_we)   r_ld_ptr <= w_last_ld ? '0 : r_ld_ptr + PTR_W'(1);

      r_stat_valid <= w_serve;
      r_load_done  <= w_last_ld;
      r_rd_valid   <= rd_en;
      r_busy       <= (w_next_state == ST_SERVE);

      if (get_data && !w_serve) r_overrun <= 1'b1;
      else if (w_nv_acc)        r_overrun <= 1'b0;

      if (w_nv_acc)      r_scores_ready <= 1'b0;
      else if (gdp_done) r_scores_ready <= 1'b1;
    end
  end

  sdp_ram #(.DEPTH(TOTAL), .WIDTH(STAT_W)) u_stat_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_ld_we),
    .i_waddr (r_ld_ptr),
    .i_wdata (load_data),
    .i_re    (w_serve),
    .i_raddr (w_stat_raddr),
    .o_rdata (stat_data)
  );

  sdp_ram #(.DEPTH(N_SENONES), .WIDTH(SCORE_W)) u_score_ram (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (write_data),
    .i_waddr (data_addr),
    .i_wdata (data_out),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign stat_valid   = r_stat_valid;
  assign load_done    = r_load_done;
  assign rd_valid     = r_rd_valid;
  assign scores_ready = r_scores_ready;
  assign busy         = r_busy;
  assign stat_overrun = r_overrun;

endmodule

// File: tb/tb_senone_store.sv
// Self-checking bench for senone_store against a sequential behavioural model
// of the stat stream, score store and status flags.
module tb_senone_store;
  import gdp_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               new_vector, get_data, write_data, gdp_done;
  logic               load_start, load_en, rd_en;
  logic [SADDR_W-1:0] data_addr, rd_addr;
  logic [SCORE_W-1:0] data_out;
  logic [STAT_W-1:0]  load_data;
  logic [STAT_W-1:0]  stat_data;
  logic [SCORE_W-1:0] rd_data;
  logic               stat_valid, load_done, rd_valid, scores_ready, busy, stat_overrun;

  always #5 clk = ~clk;

  senone_store dut (
    .clk(clk), .reset(reset), .new_vector(new_vector), .get_data(get_data),
    .stat_data(stat_data), .stat_valid(stat_valid), .write_data(write_data),
    .data_addr(data_addr), .data_out(data_out), .gdp_done(gdp_done),
    .load_start(load_start), .load_en(load_en), .load_data(load_data),
    .load_done(load_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .scores_ready(scores_ready), .busy(busy),
    .stat_overrun(stat_overrun)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model
  logic [STAT_W-1:0]  stat_model  [TOTAL];
  logic [SCORE_W-1:0] score_model [N_SENONES];
  bit                 score_known [N_SENONES];
  bit                 m_loaded, m_serving, m_overrun, m_scores;
  int                 m_ptr;
  logic [STAT_W-1:0]  m_last_stat;
  logic [SCORE_W-1:0] m_last_score;

  function automatic logic [STAT_W-1:0] pattern(input int i);
    return {16'(i), 16'(i) ^ 16'hAAAA, 16'(i)};
  endfunction

  task automatic idle_inputs();
    new_vector = 0; get_data = 0; write_data = 0; gdp_done = 0;
    load_start = 0; load_en = 0; rd_en = 0;
    data_addr = '0; rd_addr = '0; data_out = '0; load_data = '0;
  endtask

  task automatic model_reset();
    m_loaded = 0; m_serving = 0; m_overrun = 0; m_scores = 0; m_ptr = 0;
    m_last_stat = '0; m_last_score = '0;
  endtask

  // One cycle of stat-side stimulus, then compare every stat-side output.
  task automatic step_stat(input bit nv, input bit gd, input bit gdp, input string tag);
    bit exp_valid;
    exp_valid = 0;
    new_vector = nv; get_data = gd; gdp_done = gdp;
    @(posedge clk);
    if (nv && m_loaded) begin
      m_serving = 1; m_ptr = 0; m_overrun = 0; m_scores = 0;
    end else if (gdp) begin
      m_scores = 1;
    end
    if (gd) begin
      if (m_serving) begin
        exp_valid   = 1;
        m_last_stat = stat_model[m_ptr];
        m_ptr++;
        if (m_ptr == TOTAL) begin m_ptr = 0; m_serving = 0; end
      end else begin
        m_overrun = 1;
      end
    end
    @(negedge clk);
    new_vector = 0; get_data = 0; gdp_done = 0;
    n_cmp++;
    if (stat_valid !== exp_valid) begin
      n_err++; $display("FAIL %s stat_valid: got %b want %b", tag, stat_valid, exp_valid);
    end
    n_cmp++;
    if (stat_data !== m_last_stat) begin
      n_err++; $display("FAIL %s stat_data: got %h want %h", tag, stat_data, m_last_stat);
    end
    n_cmp++;
    if (stat_overrun !== m_overrun) begin
      n_err++; $display("FAIL %s stat_overrun: got %b want %b", tag, stat_overrun, m_overrun);
    end
    n_cmp++;
    if (busy !== m_serving) begin
      n_err++; $display("FAIL %s busy: got %b want %b", tag, busy, m_serving);
    end
    n_cmp++;
    if (scores_ready !== m_scores) begin
      n_err++; $display("FAIL %s scores_ready: got %b want %b", tag, scores_ready, m_scores);
    end
  endtask

  // One cycle of score-side stimulus; reads are only issued to written addresses.
  task automatic step_score(input bit we, input logic [7:0] wa, input logic [15:0] wd,
                            input bit re, input logic [7:0] ra, input string tag);
    logic [SCORE_W-1:0] old_val;
    old_val = score_model[ra];
    write_data = we; data_addr = wa; data_out = wd; rd_en = re; rd_addr = ra;
    @(posedge clk);
    if (re) m_last_score = old_val;
    if (we) begin score_model[wa] = wd; score_known[wa] = 1; end
    @(negedge clk);
    write_data = 0; rd_en = 0;
    n_cmp++;
    if (rd_valid !== re) begin
      n_err++; $display("FAIL %s rd_valid: got %b want %b", tag, rd_valid, re);
    end
    n_cmp++;
    if (rd_data !== m_last_score) begin
      n_err++; $display("FAIL %s rd_data: got %h want %h", tag, rd_data, m_last_score);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({stat_valid, load_done, rd_valid, scores_ready, busy, stat_overrun} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 000000",
                        {stat_valid, load_done, rd_valid, scores_ready, busy, stat_overrun});
    end
    n_cmp++;
    if ({stat_data, rd_data} !== '0) begin
      n_err++; $display("FAIL reset_data: got %h/%h want 0/0", stat_data, rd_data);
    end
    reset = 1;
    @(negedge clk);
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    for (int i = 0; i < 100; i++) begin
      load_en = 1; load_data = {16'($urandom), 32'($urandom)};
      @(negedge clk);
    end
    load_en = 0;
    #2 reset = 0;
    #1;
    n_cmp++;
    if ({load_done, busy, stat_valid, stat_overrun} !== 4'b0) begin
      n_err++; $display("FAIL reset_mid_load: got %b want 0000",
                        {load_done, busy, stat_valid, stat_overrun});
    end
    @(negedge clk);
    reset = 1;
    model_reset();
    step_stat(0, 1, 0, "get_after_reset");
  endtask

  task automatic test_load();
    int i, cycles, pulses;
    bit en, exp_done;
    i = 0; cycles = 0; pulses = 0;
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    while (i < TOTAL && cycles < 3 * TOTAL) begin
      en = ($urandom_range(0, 7) != 0);
      load_en   = en;
      load_data = en ? pattern(i) : {16'($urandom), 32'($urandom)};
      @(negedge clk);
      cycles++;
      exp_done = en && (i == TOTAL - 1);
      if (en) begin stat_model[i] = pattern(i); i++; end
      if (load_done === 1'b1) pulses++;
      n_cmp++;
      if (load_done !== exp_done) begin
        n_err++; $display("FAIL load_done word %0d: got %b want %b", i, load_done, exp_done);
      end
    end
    load_en = 0;
    n_cmp++;
    if (i != TOTAL) begin
      n_err++; $display("FAIL load_budget: got %0d words want %0d", i, TOTAL);
    end
    @(negedge clk);
    if (load_done === 1'b1) pulses++;
    n_cmp++;
    if (pulses != 1) begin
      n_err++; $display("FAIL load_done_pulses: got %0d want 1", pulses);
    end
    m_loaded = 1;
    step_stat(0, 0, 0, "ready_idle");
  endtask

  task automatic test_scores();
    logic [7:0] a;
    step_score(1, 8'h05, 16'h0BAD, 0, 8'h00, "score_pre");
    step_score(1, 8'h05, 16'h1234, 1, 8'h05, "score_read_first");
    step_score(0, 8'h00, 16'h0000, 1, 8'h05, "score_read_new");
    for (int k = 0; k < 200; k++) begin
      a = 8'($urandom);
      step_score(1'($urandom), 8'($urandom), 16'($urandom),
                 score_known[a] && ($urandom_range(0, 1) == 1), a, "score_rand");
    end
    step_stat(0, 0, 1, "gdp_done");
    step_stat(0, 0, 0, "scores_hold");
    step_stat(1, 0, 1, "gdp_vs_new_vector");
  endtask

  task automatic test_stream();
    step_stat(1, 0, 0, "stream_start");
    for (int i = 0; i < TOTAL; i++) step_stat(0, 1, 0, "stream");
    step_stat(0, 0, 0, "stream_end");
  endtask

  task automatic test_overrun();
    step_stat(0, 1, 0, "overrun_ready");
    step_stat(0, 0, 0, "overrun_sticky");
    step_stat(1, 0, 0, "overrun_clear");
  endtask

  task automatic test_restart();
    int n;
    for (int i = 0; i < 36; i++) step_stat(0, 1, 0, "pre_restart");
    step_stat(1, 1, 0, "restart_get37");
    step_stat(0, 1, 0, "restart_next");
    for (int i = 0; i < 400; i++)
      step_stat($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, "random_stream");
    n = 0;
    while (m_serving && n < TOTAL + 10) begin
      step_stat(0, 1, 0, "drain");
      n++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    for (int k = 0; k < 60; k++) begin
      a = 8'h05;
      if (k % 3 != 0) a = 8'($urandom);
      if (!score_known[a]) a = 8'h05;
      step_score($urandom_range(0, 1) == 1, (k % 4 == 0) ? a : 8'($urandom),
                 16'($urandom), 1, a, "b2b_read");
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_scores();
    test_stream();
    test_overrun();
    test_restart();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
